ex_mem_skid: RTL and testbench

- Parametrised EX/MEM stage register: successor to the plain EX-to-MEM write-back latch.
- Adds valid/ready handshake, a 2-entry skid buffer so `ex_ready` is a registered signal, and synchronous pipeline flush.
- Sits between the execute stage and the memory-access stage; carries register write-back info downstream in order, with no loss or duplication.

---
 rtl/ex_mem_skid.sv | 137 +++++++++++++
 tb/tb_ex_mem_skid.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid.sv
// EX/MEM stage register with a valid/ready handshake, a two-entry skid buffer and a synchronous flush.
// Defining EX_MEM_SKID_HILO_EN adds HI/LO write-back fields alongside the register write-back.
module ex_mem_skid #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NOP_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
`ifdef EX_MEM_SKID_HILO_EN
  input  logic              ex_whilo,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  output logic              mem_whilo,
  output logic [DATA_W-1:0] mem_hi,
  output logic [DATA_W-1:0] mem_lo,
`endif
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata
);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
`ifdef EX_MEM_SKID_HILO_EN
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
`endif
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  // An empty slot always holds this value, so the outputs need no gating.
  localparam entry_t NOP_ENTRY = '{wd: ADDR_W'(NOP_ADDR), default: '0};

  state_t state_reg;
  entry_t main_reg;
  entry_t skid_reg;
  entry_t in_entry;
  logic   ready_reg;
  logic   valid_reg;
  logic   accept;
  logic   pop;

  assign accept = ex_valid && ready_reg;
  assign pop    = valid_reg && mem_ready;

  always_comb begin
    in_entry       = NOP_ENTRY;
    in_entry.wd    = ex_wd;
    in_entry.wreg  = ex_wreg;
    in_entry.wdata = ex_wdata;
`ifdef EX_MEM_SKID_HILO_EN
    in_entry.whilo = ex_whilo;
    in_entry.hi    = ex_hi;
    in_entry.lo    = ex_lo;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_EMPTY;
      main_reg  <= NOP_ENTRY;
      skid_reg  <= NOP_ENTRY;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
    end else if (flush) begin
      state_reg <= S_EMPTY;
      main_reg  <= NOP_ENTRY;
      skid_reg  <= NOP_ENTRY;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_EMPTY: begin
          if (accept) begin
            main_reg  <= in_entry;
            state_reg <= S_ONE;
            valid_reg <= 1'b1;
          end
        end
        S_ONE: begin
          if (accept && pop) begin
            main_reg <= in_entry;
          end else if (accept) begin
            // Downstream stalled: park the younger entry and drop ready.
            skid_reg  <= in_entry;
            state_reg <= S_TWO;
            ready_reg <= 1'b0;
          end else if (pop) begin
            main_reg  <= NOP_ENTRY;
            state_reg <= S_EMPTY;
            valid_reg <= 1'b0;
          end
        end
        S_TWO: begin
          if (pop) begin
            main_reg  <= skid_reg;
            skid_reg  <= NOP_ENTRY;
            state_reg <= S_ONE;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= S_EMPTY;
          main_reg  <= NOP_ENTRY;
          skid_reg  <= NOP_ENTRY;
          ready_reg <= 1'b1;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ex_ready  = ready_reg;
  assign mem_valid = valid_reg;
  assign mem_wd    = main_reg.wd;
  assign mem_wreg  = main_reg.wreg;
  assign mem_wdata = main_reg.wdata;
`ifdef EX_MEM_SKID_HILO_EN
  assign mem_whilo = main_reg.whilo;
  assign mem_hi    = main_reg.hi;
  assign mem_lo    = main_reg.lo;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Scoreboard bench for ex_mem_skid: accepted entries are queued, a monitor pops and compares on every output handshake.
// Exercises the HI/LO fields when EX_MEM_SKID_HILO_EN is defined.
module tb_ex_mem_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [4:0]  ex_wd = '0;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_wdata = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
`ifdef EX_MEM_SKID_HILO_EN
  logic        ex_whilo = 1'b0;
  logic [31:0] ex_hi = '0;
  logic [31:0] ex_lo = '0;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
`endif

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  ex_mem_skid #(.DATA_W(32), .ADDR_W(5), .NOP_ADDR(0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
`ifdef EX_MEM_SKID_HILO_EN
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
`endif
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the entry is queued only if the DUT really takes it.
  task automatic drive(input logic v, input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                       input logic mr, input logic fl);
    exp_t e;
    logic acc;
    ex_valid = v; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
`ifdef EX_MEM_SKID_HILO_EN
    ex_whilo = whilo; ex_hi = hi; ex_lo = lo;
`endif
    mem_ready = mr; flush = fl;
    e = '{wd, wreg, wdata, whilo, hi, lo};
    @(negedge clk);
    acc = v && ex_ready && !fl;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else if (acc) q.push_back(e);
    $display("cycle: v=%0b wd=%0d mr=%0b fl=%0b acc=%0b -> mem_valid=%0b mem_wd=%0d ex_ready=%0b",
             v, wd, mr, fl, acc, mem_valid, mem_wd, ex_ready);
  endtask

  task automatic idle(input logic mr);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, mr, 1'b0);
  endtask

  // Monitor: every output handshake must match the oldest accepted entry.
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    if (!rst && mem_valid && mem_ready) begin
`ifdef EX_MEM_SKID_HILO_EN
      act = '{mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo};
`else
      act = '{mem_wd, mem_wreg, mem_wdata, 1'b0, 32'h0, 32'h0};
`endif
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got wd=%0d wdata=%h expected no valid entry", act.wd, act.wdata);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL pop_entry: got wd=%0d wreg=%0b wdata=%h whilo=%0b hi=%h lo=%h expected wd=%0d wreg=%0b wdata=%h whilo=%0b hi=%h lo=%h",
                   act.wd, act.wreg, act.wdata, act.whilo, act.hi, act.lo,
                   e.wd, e.wreg, e.wdata, e.whilo, e.hi, e.lo);
        end else begin
          $display("pop: wd=%0d wreg=%0b wdata=%h", act.wd, act.wreg, act.wdata);
        end
      end
    end
  end

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_wd", 32'(mem_wd), 32'd0);
    chk("rst_wreg", 32'(mem_wreg), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_ready", 32'(ex_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Streaming with no backpressure.
    drive(1'b1, 5'd3, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("stream_lat_valid", 32'(mem_valid), 32'd1);
    chk("stream_lat_wd", 32'(mem_wd), 32'd3);
    drive(1'b1, 5'd4, 1'b1, 32'h12345678, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("stream_b2b_wd", 32'(mem_wd), 32'd4);
    chk("stream_ready", 32'(ex_ready), 32'd1);
    idle(1'b1);
    chk("stream_drained", 32'(mem_valid), 32'd0);
    chk("stream_nop_wd", 32'(mem_wd), 32'd0);

    // Backpressure: A, B fill the stage; C must wait; B is a wreg=0 entry.
    drive(1'b1, 5'd1, 1'b1, 32'h0000_00A1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("bp_a_ready", 32'(ex_ready), 32'd1);
    drive(1'b1, 5'd2, 1'b0, 32'h0000_00B2, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("bp_b_ready", 32'(ex_ready), 32'd0);
    chk("bp_head_a", 32'(mem_wd), 32'd1);
    drive(1'b1, 5'd5, 1'b1, 32'h0000_00C5, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("bp_c_blocked", 32'(mem_wd), 32'd1);
    chk("bp_still_full", 32'(ex_ready), 32'd0);
    drive(1'b1, 5'd5, 1'b1, 32'h0000_00C5, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bp_head_b", 32'(mem_wd), 32'd2);
    chk("bp_ready_back", 32'(ex_ready), 32'd1);
    drive(1'b1, 5'd5, 1'b1, 32'h0000_00C5, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bp_head_c", 32'(mem_wd), 32'd5);
    idle(1'b1);
    chk("bp_drained", 32'(mem_valid), 32'd0);

    // Flush in TWO beats both a same-cycle offer and a same-cycle pop.
    drive(1'b1, 5'd1, 1'b1, 32'h1111_1111, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 5'd2, 1'b1, 32'h2222_2222, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("fl_full", 32'(ex_ready), 32'd0);
    drive(1'b1, 5'd7, 1'b1, 32'h7777_7777, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("fl_valid", 32'(mem_valid), 32'd0);
    chk("fl_wd", 32'(mem_wd), 32'd0);
    chk("fl_wdata", mem_wdata, 32'd0);
    chk("fl_ready", 32'(ex_ready), 32'd1);
    idle(1'b1);
    idle(1'b1);
    chk("fl_no_stale", 32'(mem_valid), 32'd0);

    // Asynchronous reset while holding two entries.
    drive(1'b1, 5'd8, 1'b1, 32'h8888_8888, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 5'd9, 1'b1, 32'h9999_9999, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    ex_valid = 1'b0;
    mem_ready = 1'b1;
    #2 rst = 1'b1;
    q.delete();
    #1;
    chk("arst_valid", 32'(mem_valid), 32'd0);
    chk("arst_wd", 32'(mem_wd), 32'd0);
    chk("arst_wdata", mem_wdata, 32'd0);
    chk("arst_ready", 32'(ex_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1'b1);
    chk("arst_no_stale", 32'(mem_valid), 32'd0);

`ifdef EX_MEM_SKID_HILO_EN
    // HI/LO fields travel with their entry through the skid slot.
    drive(1'b1, 5'd9, 1'b1, 32'h0000_0055, 1'b1, 32'hAAAA0000, 32'h0000BBBB, 1'b0, 1'b0);
    drive(1'b1, 5'd10, 1'b0, 32'h0000_0066, 1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    chk("hilo_hi", mem_hi, 32'hAAAA0000);
    chk("hilo_lo", mem_lo, 32'h0000BBBB);
    chk("hilo_whilo", 32'(mem_whilo), 32'd1);
    idle(1'b1);
    idle(1'b1);
    chk("hilo_idle_hi", mem_hi, 32'd0);
    chk("hilo_idle_lo", mem_lo, 32'd0);
`endif

    // Bounded drain: any entry still queued was lost by the DUT.
    mem_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1'b1);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
